mem_access_stage: RTL
=====================

# mem_access_stage

Pipeline stage 4 (memory access) of the 5-stage core. Consumes the bundle held in the stage-3 pipeline register and runs loads and stores against the data memory over a req/ack handshake. Stalls upstream while an access is outstanding. Registers the selected write-back value, destination register and write enable for the write-back stage, so it also acts as the MEM/WB pipeline register.

## Interface
- ADDR_BIT, 32, data address width; the word address is ADDR_BIT-2 bits.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `en` in 1: stage advance enable; 0 freezes the FSM and all output registers.
- `alu_data_res` in 32: effective address, or ALU result for write-back.
- `regfile_data_b` in 32: store data.
- `imm16` in 16: immediate for LUI write-back.
- `pc_4` in `IM_ADDR_BIT`: link address.
- `rd_w` in 5: resolved destination register.
- `datamem_op` in `DM_OP_BIT` (3): 0 word, 1 half unsigned, 2 half signed, 3 byte unsigned, 4 byte signed.
- `datamem_r_en` in 1: load request.
- `datamem_w_en` in 1: store request.
- `regfile_w_en` in 1: register write request.
- `wb_sel` in 2: write-back source; 0 ALU, 1 load data, 2 zero-extended pc_4, 3 {imm16,16'b0}.
- `mem_req` out 1: access request.
- `mem_we` out 1: store when 1.
- `mem_addr` out ADDR_BIT-2: word address.
- `mem_be` out 4: byte enables.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_ack` in 1: access complete this cycle; mem_rdata valid in the same cycle for reads.
- `mem_rdata` in 32: read word.
- `stall` out 1: hold stages 1–3 this cycle.
- `wb_data` out 32: registered write-back value.
- `wb_rd` out 5: registered destination register.
- `wb_w_en` out 1: registered write enable.
- `misalign` out 1: registered exception flag; present only with MEM_ALIGN_CHECK_EN.

## Operation
- access = datamem_r_en | datamem_w_en; r_en and w_en are never both 1 (the bench treats both high as illegal).
- FSM states:
  - IDLE: access & en & !ack goes to WAIT; otherwise stays in IDLE.
  - WAIT: en & mem_ack goes to IDLE.
- mem_req = access in IDLE or in WAIT, gated by en. Address, be, wdata and we are driven combinationally from inputs, which upstream holds stable because stall is high.
- stall = access & !mem_ack; combinational; low whenever en=0.
- Byte lanes are little-endian; lane = alu_data_res[1:0].
  - Word: be=1111.
  - Half: be=0011 or 1100 selected by addr[1]; data replicated ×2.
  - Byte: be = 1 << addr[1:0]; data replicated ×4.
- Load extraction shifts the selected lane to bit 0, then zero- or sign-extends per datamem_op.
- Output register update, only when en=1:
  - stall=1: wb_w_en←0 (bubble inserted); wb_data and wb_rd hold.
  - stall=0: wb_data←mux(wb_sel), wb_rd←rd_w, wb_w_en←regfile_w_en & (rd_w≠0).
- Reset values: state IDLE; wb_data 0, wb_rd 0, wb_w_en 0, misalign 0. mem_req and stall go low during reset because the state is IDLE and the request gate is forced off while rst=1.
- Reset mid-access: the request is abandoned. Memory must tolerate a dropped req, and no write-back occurs.

## Timing
- Zero-wait memory (ack in the request cycle): no stall, one-cycle stage latency, result on wb_* after the next edge.
- N wait cycles: stall is high for N cycles, mem_req is high for N+1 cycles, and wb_w_en carries N bubbles before the real result.
- Non-memory instructions pass through in 1 cycle with mem_req=0.
- en=0 during WAIT: the FSM stays in WAIT. An ack arriving while en=0 is ignored, so memory must hold ack until it sees en-qualified req low.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined:
  - Misaligned access (half with addr[0]=1, or word with addr[1:0]≠0) issues no mem_req and no stall.
  - wb_w_en←0 for that instruction.
  - misalign←1 for one cycle, registered with en.
- `MEM_ALIGN_CHECK_EN` undefined:
  - The misalign port is absent.
  - Low address bits beyond the lane are ignored; half uses addr[1], word uses addr[31:2].

## Structure
- Shared `Core.vh` holds:
  - `DM_OP_*` encodings and `DM_OP_BIT`.
  - `WB_SEL_*` constants.
  - FSM state encodings `MA_IDLE`/`MA_WAIT`.
- One sub-module, `mem_lane_align`: combinational store replication/byte-enable generation and load extraction/extension.
- FSM and output registers stay in `mem_access_stage`.

## Test plan
- Store word 0xDEADBEEF at 0x10, zero wait: mem_addr=0x4, be=1111, wdata=0xDEADBEEF, stall never 1, wb_w_en=0.
- Load byte signed at 0x13, rdata=0x80112233, ack after 2 waits: stall high 2 cycles, two bubbles, then wb_data=0xFFFFFF80.
- Load half unsigned at 0x2, rdata=0xBEEF1234: wb_data=0x0000BEEF; store half 0xABCD at 0x2 gives be=1100, wdata=0xABCDABCD.
- LUI imm16=0x1234, rd_w=5: wb_data=0x12340000, wb_rd=5, wb_w_en=1; same with rd_w=0 gives wb_w_en=0.
- Assert rst during WAIT: mem_req, stall and wb_w_en are 0 immediately, and the state is IDLE after release.
- With MEM_ALIGN_CHECK_EN, load word at 0x6: mem_req stays 0, misalign pulses 1, wb_w_en=0.

Source files
------------

// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the memory-access stage: data-memory op codes,
// write-back source selects and the stage FSM states.
package mem_access_stage_pkg;

    localparam int DM_OP_BIT   = 3;
    localparam int IM_ADDR_BIT = 32;

    localparam logic [DM_OP_BIT-1:0] DM_OP_W  = 3'd0;
    localparam logic [DM_OP_BIT-1:0] DM_OP_HU = 3'd1;
    localparam logic [DM_OP_BIT-1:0] DM_OP_HS = 3'd2;
    localparam logic [DM_OP_BIT-1:0] DM_OP_BU = 3'd3;
    localparam logic [DM_OP_BIT-1:0] DM_OP_BS = 3'd4;

    localparam logic [1:0] WB_SEL_ALU = 2'd0;
    localparam logic [1:0] WB_SEL_MEM = 2'd1;
    localparam logic [1:0] WB_SEL_PC4 = 2'd2;
    localparam logic [1:0] WB_SEL_LUI = 2'd3;

    typedef enum logic {
        MA_IDLE = 1'b0,
        MA_WAIT = 1'b1
    } ma_state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane handling for the data memory: store data
// replication with byte enables, and load lane extraction with extension.
// Lanes are little-endian; lane 0 is bits [7:0].
module mem_lane_align
    import mem_access_stage_pkg::*;
(
    input  logic [DM_OP_BIT-1:0] op,
    input  logic [1:0]           lane,
    input  logic [31:0]          st_data,
    input  logic [31:0]          rd_word,
    output logic [3:0]           be,
    output logic [31:0]          wdata,
    output logic [31:0]          ld_data
);

    logic [31:0] shifted;

    // Store side: byte enables and lane-replicated write data
    always_comb begin
        be    = '1;
        wdata = st_data;
        case (op)
            DM_OP_HU, DM_OP_HS: begin
                be    = lane[1] ? 4'b1100 : 4'b0011;
                wdata = {2{st_data[15:0]}};
            end
            DM_OP_BU, DM_OP_BS: begin
                be    = 4'b0001 << lane;
                wdata = {4{st_data[7:0]}};
            end
            default: ;
        endcase
    end

    // Load side: move the addressed lane to bit 0, then zero/sign extend
    always_comb begin
        shifted = rd_word;
        case (op)
            DM_OP_HU, DM_OP_HS: shifted = rd_word >> {lane[1], 4'b0000};
            DM_OP_BU, DM_OP_BS: shifted = rd_word >> {lane, 3'b000};
            default: ;
        endcase
        ld_data = shifted;
        case (op)
            DM_OP_HU: ld_data = {16'h0000, shifted[15:0]};
            DM_OP_HS: ld_data = {{16{shifted[15]}}, shifted[15:0]};
            DM_OP_BU: ld_data = {24'h000000, shifted[7:0]};
            DM_OP_BS: ld_data = {{24{shifted[7]}}, shifted[7:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// Pipeline stage 4: data memory access over a req/ack handshake, stalling
// upstream while an access is outstanding, and the MEM/WB register.
// Optional feature macro: MEM_ALIGN_CHECK_EN (misaligned access detection,
// adds the misalign output).
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int ADDR_BIT = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [31:0]            alu_data_res,
    input  logic [31:0]            regfile_data_b,
    input  logic [15:0]            imm16,
    input  logic [IM_ADDR_BIT-1:0] pc_4,
    input  logic [4:0]             rd_w,
    input  logic [DM_OP_BIT-1:0]   datamem_op,
    input  logic                   datamem_r_en,
    input  logic                   datamem_w_en,
    input  logic                   regfile_w_en,
    input  logic [1:0]             wb_sel,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [ADDR_BIT-3:0]    mem_addr,
    output logic [3:0]             mem_be,
    output logic [31:0]            mem_wdata,
    input  logic                   mem_ack,
    input  logic [31:0]            mem_rdata,
    output logic                   stall,
    output logic [31:0]            wb_data,
    output logic [4:0]             wb_rd,
`ifdef MEM_ALIGN_CHECK_EN
    output logic                   misalign,
`endif
    output logic                   wb_w_en
);

    ma_state_e   state_q, state_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic        wb_w_en_q, wb_w_en_d;
    logic        access, access_eff, stall_int;
    logic [31:0] ld_data, wb_mux;
`ifdef MEM_ALIGN_CHECK_EN
    logic        misal;
    logic        misalign_q, misalign_d;
`endif

    mem_lane_align u_lane (
        .op      (datamem_op),
        .lane    (alu_data_res[1:0]),
        .st_data (regfile_data_b),
        .rd_word (mem_rdata),
        .be      (mem_be),
        .wdata   (mem_wdata),
        .ld_data (ld_data)
    );

    // Access qualification; a misaligned access never reaches memory
    always_comb begin
        access = datamem_r_en | datamem_w_en;
`ifdef MEM_ALIGN_CHECK_EN
        misal = access & (((datamem_op == DM_OP_W) & (alu_data_res[1:0] != 2'b00)) |
                          (((datamem_op == DM_OP_HU) | (datamem_op == DM_OP_HS)) &
                           alu_data_res[0]));
        access_eff = access & ~misal;
`else
        access_eff = access;
`endif
    end

    // Handshake outputs; reset forces the request and stall off at once
    always_comb begin
        mem_req   = access_eff & en & ~rst;
        stall_int = access_eff & en & ~rst & ~mem_ack;
        mem_we    = datamem_w_en;
        mem_addr  = alu_data_res[ADDR_BIT-1:2];
        stall     = stall_int;
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= MA_IDLE;
        else     state_q <= state_d;
    end

    // FSM next state: an ack while en=0 is ignored
    always_comb begin
        state_d = state_q;
        case (state_q)
            MA_IDLE: if (access_eff && en && !mem_ack) state_d = MA_WAIT;
            MA_WAIT: if (en && mem_ack)                state_d = MA_IDLE;
        endcase
    end

    // Write-back source select
    always_comb begin
        case (wb_sel)
            WB_SEL_ALU: wb_mux = alu_data_res;
            WB_SEL_MEM: wb_mux = ld_data;
            WB_SEL_PC4: wb_mux = 32'(pc_4);
            default:    wb_mux = {imm16, 16'h0000};
        endcase
    end

    // MEM/WB register next values: bubble while stalled, hold while en=0
    always_comb begin
        wb_data_d = wb_data_q;
        wb_rd_d   = wb_rd_q;
        wb_w_en_d = wb_w_en_q;
`ifdef MEM_ALIGN_CHECK_EN
        misalign_d = misalign_q;
`endif
        if (en) begin
            if (stall_int) begin
                wb_w_en_d = 1'b0;
            end else begin
                wb_data_d = wb_mux;
                wb_rd_d   = rd_w;
                wb_w_en_d = regfile_w_en & (rd_w != 5'd0);
`ifdef MEM_ALIGN_CHECK_EN
                wb_w_en_d = wb_w_en_d & ~misal;
`endif
            end
`ifdef MEM_ALIGN_CHECK_EN
            misalign_d = misal;
`endif
        end
    end

    // MEM/WB register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_data_q <= '0;
            wb_rd_q   <= '0;
            wb_w_en_q <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            wb_data_q <= wb_data_d;
            wb_rd_q   <= wb_rd_d;
            wb_w_en_q <= wb_w_en_d;
`ifdef MEM_ALIGN_CHECK_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    always_comb begin
        wb_data = wb_data_q;
        wb_rd   = wb_rd_q;
        wb_w_en = wb_w_en_q;
`ifdef MEM_ALIGN_CHECK_EN
        misalign = misalign_q;
`endif
    end

endmodule
